// File: rtl/blood_pkg.sv
// Shared constants and types for the health-digit overlay.
// Includes the BCD digit type, the commit FSM states and the health clamp.
package blood_pkg;

  localparam int          DIGIT_SIZE  = 64;
  localparam int          V_ACTIVE    = 480;
  localparam logic [11:0] TRANSPARENT = 12'h000;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_VB} state_t;

  typedef logic [3:0] bcd_t;

  // Two decimal digits cannot show more than 99.
  function automatic logic [6:0] clamp_health(input logic [6:0] value);
    return (value > 7'd99) ? 7'd99 : value;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a 7-bit value (0-99) into two BCD digits.
// It converts one bit per clock after start and pulses done when tens/ones are final.
module bin2bcd_seq
  import blood_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       done,
  output bcd_t       tens,
  output bcd_t       ones
);

  logic [14:0] scratch;
  logic [14:0] adjusted;
  logic [2:0]  count;
  logic        running;

  // Each BCD nibble of 5 or more gets 3 added before the shift.
  always_comb begin
    adjusted = scratch;
    if (scratch[10:7] >= 4'd5) adjusted[10:7] = scratch[10:7] + 4'd3;
    if (scratch[14:11] >= 4'd5) adjusted[14:11] = scratch[14:11] + 4'd3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= '0;
      count   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        scratch <= {8'd0, bin};
        count   <= 3'd7;
        running <= 1'b1;
      end else if (running) begin
        scratch <= {adjusted[13:0], 1'b0};
        count   <= count - 3'd1;
        if (count == 3'd1) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign tens = scratch[14:11];
  assign ones = scratch[10:7];

endmodule

// File: rtl/blood_digit_renderer.sv
// Two-digit health overlay: converts health to BCD, commits it during vblank
// and walks the glyph ROM from the pixel stream with a 2-clock output latency.
module blood_digit_renderer
  import blood_pkg::*;
#(
  parameter int X0 = 16,
  parameter int Y0 = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  health,
  input  logic        health_valid,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  output logic [5:0]  rom_row,
  output logic [5:0]  rom_col,
  output logic [3:0]  rom_digit,
  input  logic [11:0] rom_color,
  output logic [11:0] rgb,
  output logic        sprite_on,
  output logic        busy
);

  localparam logic [10:0] X_LEFT  = 11'(X0);
  localparam logic [10:0] X_MID   = 11'(X0 + DIGIT_SIZE);
  localparam logic [10:0] X_RIGHT = 11'(X0 + 2 * DIGIT_SIZE);
  localparam logic [10:0] Y_TOP   = 11'(Y0);
  localparam logic [10:0] Y_BOT   = 11'(Y0 + DIGIT_SIZE);

  state_t     state;
  logic       pending;
  logic [6:0] pend_val;
  logic       conv_start;
  logic [6:0] conv_val;
  logic       conv_done;
  bcd_t       conv_tens;
  bcd_t       conv_ones;
  bcd_t       disp_tens;
  bcd_t       disp_ones;
  logic [6:0] clamped;
  logic       in_vblank;

  assign clamped   = clamp_health(health);
  assign in_vblank = (y >= 10'(V_ACTIVE));

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .bin     (conv_val),
    .done    (conv_done),
    .tens    (conv_tens),
    .ones    (conv_ones)
  );

  // A strobe arriving during the commit cycle is converted next, behind any older pending value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      pending    <= 1'b0;
      pend_val   <= '0;
      conv_start <= 1'b0;
      conv_val   <= '0;
      disp_tens  <= '0;
      disp_ones  <= '0;
    end else begin
      conv_start <= 1'b0;
      case (state)
        IDLE: begin
          if (health_valid) begin
            conv_start <= 1'b1;
            conv_val   <= clamped;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (health_valid) begin
            pending  <= 1'b1;
            pend_val <= clamped;
          end
          if (conv_done) state <= WAIT_VB;
        end
        WAIT_VB: begin
          if (health_valid) begin
            pending  <= 1'b1;
            pend_val <= clamped;
          end
          if (in_vblank) begin
            disp_tens <= conv_tens;
            disp_ones <= conv_ones;
            if (pending) begin
              conv_start <= 1'b1;
              conv_val   <= pend_val;
              pending    <= health_valid;
              state      <= SHIFT;
            end else if (health_valid) begin
              conv_start <= 1'b1;
              conv_val   <= clamped;
              pending    <= 1'b0;
              state      <= SHIFT;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic       in_rows;
  logic       in_tens;
  logic       in_ones;
  logic       hit;
  logic [5:0] tens_col;
  logic [5:0] ones_col;
  logic [5:0] row_off;

  // Box tests use 11-bit compares so the right edge never aliases back to column 0.
  assign in_rows  = ({1'b0, y} >= Y_TOP) && ({1'b0, y} < Y_BOT);
  assign in_tens  = in_rows && ({1'b0, x} >= X_LEFT) && ({1'b0, x} < X_MID);
  assign in_ones  = in_rows && ({1'b0, x} >= X_MID) && ({1'b0, x} < X_RIGHT);
  assign row_off  = 6'(y - 10'(Y0));
  assign tens_col = 6'(x - 10'(X0));
  assign ones_col = 6'(x - 10'(X0) - 10'(DIGIT_SIZE));

  always_comb begin
    rom_row   = '0;
    rom_col   = '0;
    rom_digit = '0;
    hit       = 1'b0;
    if (in_tens) begin
      rom_row   = row_off;
      rom_col   = tens_col;
      rom_digit = disp_tens;
      hit       = (disp_tens != 4'd0);
    end else if (in_ones) begin
      rom_row   = row_off;
      rom_col   = ones_col;
      rom_digit = disp_ones;
      hit       = 1'b1;
    end
  end

  logic hit_d;
  logic sprite_next;

  assign sprite_next = hit_d && (rom_color != TRANSPARENT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_d     <= 1'b0;
      sprite_on <= 1'b0;
      rgb       <= '0;
    end else begin
      hit_d     <= hit & video_on;
      sprite_on <= sprite_next;
      rgb       <= sprite_next ? rom_color : 12'h000;
    end
  end

endmodule

// File: tb/tb_blood_digit_renderer.sv
// Self-checking bench for blood_digit_renderer: a digit/pixel model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_blood_digit_renderer;

  localparam int X0 = 16;
  localparam int Y0 = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  health = '0;
  logic        health_valid = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        video_on = 1'b0;
  logic [11:0] rom_color = '0;
  logic [5:0]  rom_row;
  logic [5:0]  rom_col;
  logic [3:0]  rom_digit;
  logic [11:0] rgb;
  logic        sprite_on;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model: displayed digits, value being converted, and the one-entry pending slot.
  int m_tens = 0;
  int m_ones = 0;
  bit fl_valid = 0;
  int fl_value = 0;
  bit pd_valid = 0;
  int pd_value = 0;

  always #5 clk = ~clk;

  blood_digit_renderer #(.X0(X0), .Y0(Y0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .health       (health),
    .health_valid (health_valid),
    .x            (x),
    .y            (y),
    .video_on     (video_on),
    .rom_row      (rom_row),
    .rom_col      (rom_col),
    .rom_digit    (rom_digit),
    .rom_color    (rom_color),
    .rgb          (rgb),
    .sprite_on    (sprite_on),
    .busy         (busy)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  function automatic void model_addr(input int xi, input int yi,
                                     output int row, output int col,
                                     output int digit, output int hitv);
    int off;
    row = 0; col = 0; digit = 0; hitv = 0;
    if (yi >= Y0 && yi < Y0 + 64 && xi >= X0 && xi < X0 + 128) begin
      off = xi - X0;
      row = yi - Y0;
      col = off % 64;
      if (off / 64 == 0) begin
        digit = m_tens;
        hitv  = (m_tens != 0);
      end else begin
        digit = m_ones;
        hitv  = 1;
      end
    end
  endfunction

  // Per-cycle compare: ROM address now, overlay pixel from hits 2 cycles back.
  initial begin : compare
    int h1, h2, c1, row, col, dig, hv, exp_sp, exp_rgb;
    h1 = 0; h2 = 0; c1 = 0;
    forever begin
      @(negedge clk);
      model_addr(int'(x), int'(y), row, col, dig, hv);
      check_output("rom_row", int'(rom_row), row);
      check_output("rom_col", int'(rom_col), col);
      check_output("rom_digit", int'(rom_digit), dig);
      if (!reset_n) begin
        exp_sp = 0; exp_rgb = 0; h1 = 0; h2 = 0; c1 = 0;
      end else begin
        exp_sp  = (h2 != 0 && c1 != 0) ? 1 : 0;
        exp_rgb = (exp_sp != 0) ? c1 : 0;
      end
      check_output("sprite_on", int'(sprite_on), exp_sp);
      check_output("rgb", int'(rgb), exp_rgb);
      if (reset_n) begin
        h2 = h1;
        h1 = (hv != 0 && video_on) ? 1 : 0;
        c1 = int'(rom_color);
      end
    end
  end

  task automatic apply_stimulus(input int xi, input int yi, input bit von, input int col);
    @(posedge clk); #1;
    x = 10'(xi);
    y = 10'(yi);
    video_on = von;
    rom_color = 12'(col);
  endtask

  task automatic model_strobe(input int v);
    int c;
    c = (v > 99) ? 99 : v;
    if (!fl_valid) begin
      fl_valid = 1; fl_value = c;
    end else begin
      pd_valid = 1; pd_value = c;
    end
  endtask

  task automatic send_health(input int v);
    @(posedge clk); #1;
    health = 7'(v);
    health_valid = 1'b1;
    model_strobe(v);
    @(posedge clk); #1;
    health_valid = 1'b0;
  endtask

  // Let the conversion finish, then hold y in vblank for two cycles.
  task automatic run_vblank(input bit with_strobe, input int v);
    int saved_y;
    int c;
    saved_y = int'(y);
    repeat (20) @(posedge clk);
    #1;
    y = 10'(480);
    if (with_strobe) begin
      health = 7'(v);
      health_valid = 1'b1;
    end
    @(posedge clk); #1;
    health_valid = 1'b0;
    if (fl_valid) begin
      m_tens = fl_value / 10;
      m_ones = fl_value % 10;
      if (pd_valid) begin
        fl_value = pd_value;
        pd_valid = 0;
        if (with_strobe) begin
          pd_valid = 1; pd_value = (v > 99) ? 99 : v;
        end
      end else if (with_strobe) begin
        fl_value = (v > 99) ? 99 : v;
      end else begin
        fl_valid = 0;
      end
    end
    check_output("busy_after_commit", int'(busy), int'(fl_valid));
    @(posedge clk); #1;
    y = 10'(saved_y);
  endtask

  task automatic check_digits(input string name, input int exp_tens, input int exp_ones);
    apply_stimulus(X0 + 10, Y0 + 10, 1'b1, 12'hE00);
    @(negedge clk);
    check_output({name, "_tens"}, int'(rom_digit), exp_tens);
    apply_stimulus(X0 + 74, Y0 + 10, 1'b1, 12'hE00);
    @(negedge clk);
    check_output({name, "_ones"}, int'(rom_digit), exp_ones);
  endtask

  task automatic pixel_after2(input int xi, input int yi, input bit von, input int col);
    apply_stimulus(xi, yi, von, col);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    x = 10'(X0 + 70); y = 10'(Y0 + 5); video_on = 1'b1; rom_color = 12'hE00;
    repeat (3) @(negedge clk);
    check_output("rgb_in_reset", int'(rgb), 0);
    check_output("busy_in_reset", int'(busy), 0);

    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_output("reset_digit", int'(rom_digit), 0);
    check_output("reset_col", int'(rom_col), 6);
    check_output("sprite_lat0", int'(sprite_on), 0);
    @(negedge clk);
    check_output("sprite_lat1", int'(sprite_on), 0);
    @(negedge clk);
    check_output("sprite_lat2", int'(sprite_on), 1);
    check_output("rgb_lat2", int'(rgb), 12'hE00);

    apply_stimulus(X0 + 10, 100, 1'b1, 12'hE00);
    send_health(57);
    check_output("busy_57", int'(busy), 1);
    check_digits("before_vb_57", 0, 0);
    run_vblank(1'b0, 0);
    check_digits("digits_57", 5, 7);

    send_health(120);
    run_vblank(1'b0, 0);
    check_digits("digits_120", 9, 9);

    send_health(7);
    run_vblank(1'b0, 0);
    pixel_after2(X0 + 10, Y0 + 10, 1'b1, 12'hF00);
    check_output("lead_zero_sprite", int'(sprite_on), 0);
    apply_stimulus(X0 + 74, Y0 + 10, 1'b1, 12'hF00);
    @(negedge clk);
    check_output("digit_7", int'(rom_digit), 7);
    repeat (2) @(negedge clk);
    check_output("ones_7_rgb", int'(rgb), 12'hF00);

    send_health(30);
    send_health(45);
    send_health(62);
    check_output("busy_pending", int'(busy), 1);
    run_vblank(1'b0, 0);
    check_digits("digits_30", 3, 0);
    run_vblank(1'b0, 0);
    check_digits("digits_62", 6, 2);
    check_output("busy_idle_62", int'(busy), 0);

    send_health(41);
    run_vblank(1'b1, 23);
    check_digits("digits_41", 4, 1);
    run_vblank(1'b0, 0);
    check_digits("digits_23", 2, 3);

    pixel_after2(X0 + 80, Y0 + 20, 1'b1, 12'h000);
    check_output("transparent_sprite", int'(sprite_on), 0);
    check_output("transparent_rgb", int'(rgb), 0);
    pixel_after2(X0 + 80, Y0 + 20, 1'b0, 12'hE00);
    check_output("blank_sprite", int'(sprite_on), 0);
    check_output("blank_rgb", int'(rgb), 0);
    apply_stimulus(X0 + 127, Y0 + 63, 1'b1, 12'hE00);
    @(negedge clk);
    check_output("edge_col", int'(rom_col), 63);
    check_output("edge_row", int'(rom_row), 63);
    pixel_after2(X0 + 128, Y0 + 63, 1'b1, 12'hE00);
    check_output("outside_col", int'(rom_col), 0);
    check_output("outside_digit", int'(rom_digit), 0);
    check_output("outside_sprite", int'(sprite_on), 0);

    send_health(88);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    m_tens = 0; m_ones = 0; fl_valid = 0; pd_valid = 0;
    #1;
    check_output("busy_reset_mid", int'(busy), 0);
    check_digits("digits_in_reset", 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    send_health(88);
    run_vblank(1'b0, 0);
    check_digits("digits_88", 8, 8);
    check_output("busy_final", int'(busy), 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
